// File: rtl/matmul_tile_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_tile_sequencer
//
// Tile-level controller in front of the matmul engine. One top-level start
// walks an M x N x K grid of tiles (K innermost, then N, then M), issuing one
// engine run per tile with A/B/C BRAM base addresses and an accumulate flag,
// and reports a single done at the end.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   When defined, a watchdog counts cycles in RUN; if the engine has not
//   signalled mm_done after TIMEOUT cycles, error is set (sticky until the
//   next LOAD or reset), mm_start is dropped and the sequence ends in DONE.
//   When undefined, error is tied low and RUN waits indefinitely.
//
// Parameters
//   AWIDTH   : width of the BRAM base-address outputs
//   TW       : width of the tile-count inputs
//   A_STRIDE : words per A tile
//   B_STRIDE : words per B tile
//   C_STRIDE : words per C tile
//   TIMEOUT  : watchdog limit in cycles (SEQ_TIMEOUT_EN only)
//
// Ports
//   clk                      in  : clock, rising edge
//   resetn                   in  : asynchronous active-low reset
//   start                    in  : level request, sampled in IDLE
//   num_m/n/k_tiles [TW]     in  : tile counts, latched in LOAD
//   mm_start                 out : engine start (level, high in RUN)
//   mm_done                  in  : engine done (level)
//   mm_accum                 out : 1 when k != 0 (accumulate into C)
//   a_base/b_base/c_base     out : engine BRAM base addresses
//   busy                     out : high in LOAD, RUN, GAP
//   done                     out : high in DONE
//   error                    out : sticky watchdog flag
// ---------------------------------------------------------------------------
module matmul_tile_sequencer #(
    parameter int AWIDTH   = 10,
    parameter int TW       = 4,
    parameter int A_STRIDE = 16,
    parameter int B_STRIDE = 16,
    parameter int C_STRIDE = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [TW-1:0]     num_m_tiles,
    input  logic [TW-1:0]     num_n_tiles,
    input  logic [TW-1:0]     num_k_tiles,
    output logic              mm_start,
    input  logic              mm_done,
    output logic              mm_accum,
    output logic [AWIDTH-1:0] a_base,
    output logic [AWIDTH-1:0] b_base,
    output logic [AWIDTH-1:0] c_base,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [AWIDTH-1:0] A_STEP = AWIDTH'(A_STRIDE);
    localparam logic [AWIDTH-1:0] B_STEP = AWIDTH'(B_STRIDE);
    localparam logic [AWIDTH-1:0] C_STEP = AWIDTH'(C_STRIDE);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("matmul_tile_sequencer: TIMEOUT must be at least 1");
    end

    // count * stride built from shifted adds of the stride; used once per
    // sequence to form the k-step of the B address (N * B_STRIDE).
    function automatic logic [AWIDTH-1:0] stride_mul(
        input logic [TW-1:0]     cnt,
        input logic [AWIDTH-1:0] stride
    );
        logic [AWIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < TW; i++) begin
            if (cnt[i]) begin
                acc = acc + (stride << i);
            end
        end
        return acc;
    endfunction

    state_t            state;
    state_t            state_nxt;

    logic [TW-1:0]     m_max;
    logic [TW-1:0]     n_max;
    logic [TW-1:0]     k_max;
    logic [TW-1:0]     m_idx;
    logic [TW-1:0]     n_idx;
    logic [TW-1:0]     k_idx;

    // a_row holds (m*K)*A_STRIDE, b_col holds n*B_STRIDE, b_kstep N*B_STRIDE.
    logic [AWIDTH-1:0] a_row;
    logic [AWIDTH-1:0] b_col;
    logic [AWIDTH-1:0] b_kstep;
    logic              last_tile;

    logic              k_last;
    logic              n_last;
    logic              m_last;
    logic              any_zero;
    logic              timed_out;
    logic              tile_done;

    assign k_last   = (k_idx == k_max - 1'b1);
    assign n_last   = (n_idx == n_max - 1'b1);
    assign m_last   = (m_idx == m_max - 1'b1);
    assign any_zero = (num_m_tiles == '0) || (num_n_tiles == '0) ||
                      (num_k_tiles == '0);

`ifdef SEQ_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);

    logic [TCW-1:0] wd_cnt;
    logic           wd_hit;

    // Fires in the last allowed RUN cycle so error and the dropped mm_start
    // appear together exactly TIMEOUT cycles after RUN entry.
    assign wd_hit = (state == S_RUN) && !mm_done && !error &&
                    (wd_cnt == TCW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            if (state == S_RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (state == S_LOAD) begin
                error <= 1'b0;
            end else if (wd_hit) begin
                error <= 1'b1;
            end
        end
    end

    assign timed_out = error;
`else
    assign error     = 1'b0;
    assign timed_out = 1'b0;
`endif

    assign tile_done = (state == S_RUN) && mm_done && !timed_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = any_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (timed_out) begin
                    state_nxt = S_DONE;
                end else if (mm_done) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                // Hold off the next run until the engine releases mm_done.
                if (!mm_done) begin
                    state_nxt = last_tile ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mm_start = (state == S_RUN) && !timed_out;
    assign busy     = (state == S_LOAD) || (state == S_RUN) || (state == S_GAP);
    assign done     = (state == S_DONE);

    // Tile counters and base addresses advance on the RUN->GAP edge, so the
    // new bases are settled throughout GAP and constant for the next RUN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_max     <= '0;
            n_max     <= '0;
            k_max     <= '0;
            m_idx     <= '0;
            n_idx     <= '0;
            k_idx     <= '0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            a_row     <= '0;
            b_col     <= '0;
            b_kstep   <= '0;
            mm_accum  <= 1'b0;
            last_tile <= 1'b0;
        end else if (state == S_LOAD) begin
            m_max     <= num_m_tiles;
            n_max     <= num_n_tiles;
            k_max     <= num_k_tiles;
            m_idx     <= '0;
            n_idx     <= '0;
            k_idx     <= '0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            a_row     <= '0;
            b_col     <= '0;
            b_kstep   <= stride_mul(num_n_tiles, B_STEP);
            mm_accum  <= 1'b0;
            last_tile <= 1'b0;
        end else if (tile_done) begin
            last_tile <= m_last && n_last && k_last;
            if (!k_last) begin
                k_idx    <= k_idx + 1'b1;
                a_base   <= a_base + A_STEP;
                b_base   <= b_base + b_kstep;
                mm_accum <= 1'b1;
            end else begin
                k_idx    <= '0;
                mm_accum <= 1'b0;
                // (m*N+n) advances by one whenever the K loop wraps.
                c_base   <= c_base + C_STEP;
                if (!n_last) begin
                    n_idx  <= n_idx + 1'b1;
                    a_base <= a_row;
                    b_col  <= b_col + B_STEP;
                    b_base <= b_col + B_STEP;
                end else begin
                    n_idx  <= '0;
                    m_idx  <= m_idx + 1'b1;
                    // Last A tile of row m plus one stride is the first of m+1.
                    a_row  <= a_base + A_STEP;
                    a_base <= a_base + A_STEP;
                    b_col  <= '0;
                    b_base <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
module tb_matmul_tile_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [3:0] nm, nn, nk;
    logic       mm_start, mm_done, mm_accum;
    logic [9:0] a_base, b_base, c_base;
    logic       busy, done, error;

    logic       start6;
    logic [3:0] nm6, nn6, nk6;
    logic       mm_start6, mm_done6, mm_accum6;
    logic [5:0] a6, b6, c6;
    logic       busy6, done6, error6;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matmul_tile_sequencer #(
        .AWIDTH(10), .TW(4), .A_STRIDE(16), .B_STRIDE(16), .C_STRIDE(16), .TIMEOUT(20)
    ) u_dut (
        .clk(clk), .resetn(resetn), .start(start),
        .num_m_tiles(nm), .num_n_tiles(nn), .num_k_tiles(nk),
        .mm_start(mm_start), .mm_done(mm_done), .mm_accum(mm_accum),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy), .done(done), .error(error)
    );

    matmul_tile_sequencer #(
        .AWIDTH(6), .TW(4), .A_STRIDE(16), .B_STRIDE(16), .C_STRIDE(16), .TIMEOUT(1023)
    ) u_dut6 (
        .clk(clk), .resetn(resetn), .start(start6),
        .num_m_tiles(nm6), .num_n_tiles(nn6), .num_k_tiles(nk6),
        .mm_start(mm_start6), .mm_done(mm_done6), .mm_accum(mm_accum6),
        .a_base(a6), .b_base(b6), .c_base(c6),
        .busy(busy6), .done(done6), .error(error6)
    );

    // Engine model for the main DUT: mm_done rises eng_lat cycles after
    // mm_start and stays high eng_hold cycles; eng_off means it never answers.
    int eng_lat, eng_hold;
    bit eng_off;
    int e_cnt, e_hold_left;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mm_done     <= 1'b0;
            e_cnt       <= 0;
            e_hold_left <= 0;
        end else if (mm_done) begin
            if (e_hold_left <= 1) mm_done <= 1'b0;
            else e_hold_left <= e_hold_left - 1;
        end else if (mm_start && !eng_off) begin
            if (e_cnt >= eng_lat - 1) begin
                mm_done     <= 1'b1;
                e_hold_left <= eng_hold;
                e_cnt       <= 0;
            end else begin
                e_cnt <= e_cnt + 1;
            end
        end else begin
            e_cnt <= 0;
        end
    end

    // Engine model for the narrow-address DUT: done 3 cycles after start, 1 cycle wide.
    int e6_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mm_done6 <= 1'b0;
            e6_cnt   <= 0;
        end else if (mm_done6) begin
            mm_done6 <= 1'b0;
        end else if (mm_start6) begin
            if (e6_cnt >= 2) begin
                mm_done6 <= 1'b1;
                e6_cnt   <= 0;
            end else begin
                e6_cnt <= e6_cnt + 1;
            end
        end else begin
            e6_cnt <= 0;
        end
    end

    // Run recorder: one entry per mm_start rise, with the number of
    // busy-but-not-running cycles that preceded it.
    int   q_a[$], q_b[$], q_c[$], q_acc[$], q_gap[$], q_a6[$];
    logic prev_ms = 1'b0, prev_ms6 = 1'b0;
    int   gap_cnt = 0, unstable = 0;
    logic [9:0] cur_a, cur_b, cur_c;

    always @(negedge clk) begin
        if (mm_start && !prev_ms) begin
            q_a.push_back(int'(a_base));
            q_b.push_back(int'(b_base));
            q_c.push_back(int'(c_base));
            q_acc.push_back(int'(mm_accum));
            q_gap.push_back(gap_cnt);
            cur_a   <= a_base;
            cur_b   <= b_base;
            cur_c   <= c_base;
            gap_cnt <= 0;
        end else if (mm_start) begin
            if (a_base != cur_a || b_base != cur_b || c_base != cur_c)
                unstable <= unstable + 1;
        end else if (busy) begin
            gap_cnt <= gap_cnt + 1;
        end else begin
            gap_cnt <= 0;
        end
        prev_ms <= mm_start;
        if (mm_start6 && !prev_ms6) q_a6.push_back(int'(a6));
        prev_ms6 <= mm_start6;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && !done; i++) tick();
        check_vec(tag, 32'(done), 32'd1);
    endtask

    task automatic drop_start(input string tag);
        start = 1'b0;
        tick();
        check_vec({tag, "_done_low"}, 32'(done), 32'd0);
        check_vec({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic int qget(input int idx, input int sel);
        if (idx >= q_a.size()) return -1;
        case (sel)
            0: return q_a[idx];
            1: return q_b[idx];
            2: return q_c[idx];
            3: return q_acc[idx];
            default: return q_gap[idx];
        endcase
    endfunction

    localparam int EXP_A[8]   = '{0, 16, 0, 16, 32, 48, 32, 48};
    localparam int EXP_B[8]   = '{0, 32, 16, 48, 0, 32, 16, 48};
    localparam int EXP_C[8]   = '{0, 0, 16, 16, 32, 32, 48, 48};
    localparam int EXP_ACC[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    localparam int EXP_A6[5]  = '{0, 16, 32, 48, 0};

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int nrun;
        resetn = 1'b0; start = 1'b0; start6 = 1'b0;
        nm = 4'd0; nn = 4'd0; nk = 4'd0;
        nm6 = 4'd1; nn6 = 4'd1; nk6 = 4'd5;
        eng_lat = 10; eng_hold = 1; eng_off = 1'b0;
        repeat (3) tick();

        // Reset state
        check_vec("rst_mm_start", 32'(mm_start), 0);
        check_vec("rst_busy",     32'(busy), 0);
        check_vec("rst_done",     32'(done), 0);
        check_vec("rst_error",    32'(error), 0);
        check_vec("rst_bases",    32'(a_base | b_base | c_base), 0);
        check_vec("rst_accum",    32'(mm_accum), 0);
        resetn = 1'b1;
        tick();

        // 1x1x1: LOAD in cycle 1, RUN in cycle 2, done held while start high
        base = q_a.size();
        nm = 4'd1; nn = 4'd1; nk = 4'd1; start = 1'b1;
        tick();
        check_vec("t1_load_busy",  32'(busy), 1);
        check_vec("t1_load_nostart", 32'(mm_start), 0);
        tick();
        check_vec("t1_run_start", 32'(mm_start), 1);
        wait_done("t1_done", 100);
        check_vec("t1_runs",  q_a.size() - base, 1);
        check_vec("t1_a",     qget(base, 0), 0);
        check_vec("t1_b",     qget(base, 1), 0);
        check_vec("t1_c",     qget(base, 2), 0);
        check_vec("t1_accum", qget(base, 3), 0);
        repeat (4) tick();
        check_vec("t1_done_held", 32'(done), 1);
        drop_start("t1");

        // 2x2x2: eight runs in order, one GAP cycle between runs
        base = q_a.size();
        nm = 4'd2; nn = 4'd2; nk = 4'd2; start = 1'b1;
        wait_done("t2_done", 400);
        check_vec("t2_runs", q_a.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            check_vec($sformatf("t2_a%0d", i),   qget(base + i, 0), EXP_A[i]);
            check_vec($sformatf("t2_b%0d", i),   qget(base + i, 1), EXP_B[i]);
            check_vec($sformatf("t2_c%0d", i),   qget(base + i, 2), EXP_C[i]);
            check_vec($sformatf("t2_acc%0d", i), qget(base + i, 3), EXP_ACC[i]);
            check_vec($sformatf("t2_gap%0d", i), qget(base + i, 4), 1);
        end
        drop_start("t2");

        // Zero K count: no run, done in cycle 2, one cycle wide once start drops
        base = q_a.size();
        nm = 4'd2; nn = 4'd2; nk = 4'd0; start = 1'b1;
        tick();
        check_vec("t3_load_busy", 32'(busy), 1);
        tick();
        check_vec("t3_done_c2", 32'(done), 1);
        check_vec("t3_no_start", 32'(mm_start), 0);
        drop_start("t3");
        check_vec("t3_runs", q_a.size() - base, 0);

        // mm_done held 3 cycles: GAP lasts 3 cycles before the next run
        base = q_a.size();
        eng_hold = 3;
        nm = 4'd1; nn = 4'd1; nk = 4'd2; start = 1'b1;
        wait_done("t4_done", 200);
        check_vec("t4_runs", q_a.size() - base, 2);
        check_vec("t4_gap1", qget(base + 1, 4), 3);
        check_vec("t4_acc1", qget(base + 1, 3), 1);
        check_vec("t4_a1",   qget(base + 1, 0), 16);
        drop_start("t4");
        eng_hold = 1;

        // Reset asserted during the 3rd run of 2x2x2
        base = q_a.size();
        nm = 4'd2; nn = 4'd2; nk = 4'd2; start = 1'b1;
        for (int i = 0; i < 200 && (q_a.size() - base) < 3; i++) tick();
        check_vec("t5_reached_run3", q_a.size() - base, 3);
        check_vec("t5_running", 32'(mm_start), 1);
        start = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_vec("t5_async_mm_start", 32'(mm_start), 0);
        check_vec("t5_async_busy",     32'(busy), 0);
        check_vec("t5_async_bases",    32'(a_base | b_base | c_base), 0);
        check_vec("t5_async_accum",    32'(mm_accum | done | error), 0);
        nrun = q_a.size();
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) tick();
        check_vec("t5_idle_busy",  32'(busy), 0);
        check_vec("t5_idle_start", 32'(mm_start), 0);
        check_vec("t5_no_resume",  q_a.size(), nrun);

        // Narrow address bus: A base wraps mod 64
        start6 = 1'b1;
        for (int i = 0; i < 200 && !done6; i++) tick();
        check_vec("t6_done", 32'(done6), 1);
        check_vec("t6_runs", q_a6.size(), 5);
        for (int i = 0; i < 5; i++)
            check_vec($sformatf("t6_a%0d", i), (i < q_a6.size()) ? q_a6[i] : -1, EXP_A6[i]);
        start6 = 1'b0;
        tick();
        check_vec("t6_done_low", 32'(done6), 0);

        // Engine never answers
        eng_off = 1'b1;
        nm = 4'd1; nn = 4'd1; nk = 4'd1; start = 1'b1;
        tick();
        tick();
        check_vec("t7_run_start", 32'(mm_start), 1);
`ifdef SEQ_TIMEOUT_EN
        repeat (19) tick();
        check_vec("t7_pre_error", 32'(error), 0);
        check_vec("t7_pre_start", 32'(mm_start), 1);
        tick();
        check_vec("t7_error",     32'(error), 1);
        check_vec("t7_start_off", 32'(mm_start), 0);
        check_vec("t7_not_done",  32'(done), 0);
        tick();
        check_vec("t7_done", 32'(done), 1);
        start = 1'b0;
        tick();
        check_vec("t7_sticky", 32'(error), 1);
        check_vec("t7_idle",   32'(busy), 0);
`else
        repeat (1000) tick();
        check_vec("t7_still_run", 32'(mm_start), 1);
        check_vec("t7_busy",      32'(busy), 1);
        check_vec("t7_no_error",  32'(error), 0);
        check_vec("t7_not_done",  32'(done), 0);
        start = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
`endif
        eng_off = 1'b0;
        tick();

        check_vec("bases_stable_in_run", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_tile_sequencer.md
# matmul_tile_sequencer

Tile-level controller that sits in front of the `conv`/matmul engine and drives its `start`/`done` handshake. It walks an M×N×K grid of tiles, with K innermost. For each tile it issues one engine run with the A, B and C BRAM base addresses and an accumulate flag. One top-level `start` therefore yields a full multi-tile matrix product, and a single `done` is reported at the end.

## Interface
- `AWIDTH`, 10: width of BRAM base-address outputs (1024-word RAMs).
- `TW`, 4: width of tile-count inputs.
- `A_STRIDE`, 16: words per A tile.
- `B_STRIDE`, 16: words per B tile.
- `C_STRIDE`, 16: words per C tile.
- `TIMEOUT`, 1023: watchdog limit in cycles; used only with `SEQ_TIMEOUT_EN`.

- `clk` in 1: single clock, all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: level request; sampled in IDLE.
- `num_m_tiles`, `num_n_tiles`, `num_k_tiles` in TW each: tile counts; latched in LOAD.
- `mm_start` out 1: engine start, level.
- `mm_done` in 1: engine done, level.
- `mm_accum` out 1: 1 when k≠0, meaning add into existing C.
- `a_base`, `b_base`, `c_base` out AWIDTH each: engine BRAM base addresses.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `error` out 1: sticky watchdog flag; tied 0 without the macro.

## Operation
- States are IDLE, LOAD, RUN, GAP and DONE.
- **IDLE**
  - `start`=1 → LOAD.
- **LOAD**
  - Latches the three counts and clears counters m, n, k.
  - If any count is 0 → DONE, with no engine run.
  - Otherwise → RUN.
- **RUN**
  - `mm_start`=1.
  - Bases and `mm_accum` are registered and stable for the whole state.
  - `mm_done`=1 → GAP.
- **GAP**
  - `mm_start`=0 and counters advance: k++. On k wrap, k=0 and n++. On n wrap, n=0 and m++.
  - Stays in GAP while `mm_done`=1; minimum 1 cycle.
  - If the completed tile was the last one (m,n,k all at max−1) → DONE.
  - Otherwise → RUN with the new bases.
- **DONE**
  - `done`=1.
  - `start`=0 → IDLE.
  - If `start` is already low on entry, `done` is high exactly 1 cycle.
- Address formulas, each result truncated mod 2^AWIDTH (wraps silently):
  - `a_base` = (m·K + k)·A_STRIDE
  - `b_base` = (k·N + n)·B_STRIDE
  - `c_base` = (m·N + n)·C_STRIDE
- Address arithmetic is implemented with incremental adders; no multipliers.
- `start` falling mid-sequence is ignored; the sequence completes.
- Config inputs are ignored outside LOAD.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - `resetn` low mid-run clears all outputs asynchronously.
  - No engine run resumes after reset is released.
- Edge 0 samples `start`=1 → cycle 1 is LOAD → cycle 2 is RUN with `mm_start`=1 and bases valid.
- Zero-count case: `done` rises in cycle 2.
- The `mm_done` rise is seen at edge t → `mm_start`=0 from t+1 → next RUN no earlier than t+2, and only after `mm_done` has fallen.
- Per-tile overhead is 1 GAP cycle beyond the engine's `done` latency.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A counter runs in RUN and is cleared on RUN entry.
  - When it reaches TIMEOUT without `mm_done`, `error` is set sticky, `mm_start` is dropped and the state → DONE.
  - `error` clears only on reset or on LOAD.
- `SEQ_TIMEOUT_EN` not defined:
  - No counter is built and `error`=0.
  - RUN waits indefinitely for `mm_done`.

## Test plan
- M=N=K=1, engine model with done 10 cycles after start:
  - one `mm_start` run with bases 0/0/0 and `mm_accum`=0;
  - `done` is held until `start` goes low, then IDLE.
- M=N=K=2, strides 16, 8 runs in order, with one GAP cycle between runs:
  - `a_base` = 0, 16, 0, 16, 32, 48, 32, 48
  - `b_base` = 0, 32, 16, 48, 0, 32, 16, 48
  - `c_base` = 0, 0, 16, 16, 32, 32, 48, 48
  - `mm_accum` = 0, 1, 0, 1, 0, 1, 0, 1
- `num_k_tiles`=0 → no `mm_start`; `done`=1 in cycle 2. Drop `start` → `done`=0 next cycle.
- AWIDTH=6, M=N=1, K=5, A_STRIDE=16 → `a_base` = 0, 16, 32, 48, 0 (wrap).
- Engine holds `mm_done` high 3 cycles → sequencer stays in GAP 3 cycles, then the next RUN starts.
- `resetn`=0 during the 3rd RUN of the 2×2×2 case → all outputs 0 immediately. After release with `start`=0, the sequencer stays IDLE.
- With `SEQ_TIMEOUT_EN` and TIMEOUT=20, engine never asserts done:
  - `error`=1 and `mm_start`=0 20 cycles after `mm_start` rises;
  - `done`=1 the cycle after.
- Without `SEQ_TIMEOUT_EN`, the same stimulus leaves the sequencer in RUN after 1000 cycles with `error`=0.
